// File: rtl/audio_pkg.sv
// Shared constants and types for the audio channel scheduler slice.
package audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int NUM_CH_DEF = 4;
  localparam int CH_ID_W    = $clog2(NUM_CH_DEF);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding processed samples with their channel id.
module audio_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_rd;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, do_rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign rd_data = valid ? mem[rd_ptr_q] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && (count_q == (AW+1)'(DEPTH))))
    else $error("audio_sample_fifo: write while full");
endmodule

// File: rtl/audio_channel_scheduler.sv
// Round-robin scheduler sharing one audio preprocessor among NUM_CH channels,
// re-tagging its results and buffering them in order in a credit-limited FIFO.
module audio_channel_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int PP_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [SAMPLE_W*NUM_CH-1:0] ch_data,
  output logic [SAMPLE_W-1:0]        pp_in,
  input  logic [SAMPLE_W-1:0]        pp_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SAMPLE_W-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       busy
);
  localparam int CW = $clog2(NUM_CH);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = CW + SAMPLE_W;

  logic [CW-1:0]               rr_ptr_q, rr_ptr_d, gnt_idx, scan_idx;
  logic                        gnt_found, credit_ok, xfer, fifo_wr;
  sample_t                     pp_in_q, pp_in_d;
  logic [PP_LATENCY:0]         tag_v_q, tag_v_d;
  logic [PP_LATENCY:0][CW-1:0] tag_ch_q, tag_ch_d;
  logic [NW-1:0]               inflight_q, inflight_d, fifo_count;
  logic [EW-1:0]               fifo_rd_data;

  // Credit counts every tagged sample so the FIFO can always absorb what is in flight.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (NW+1)'(FIFO_DEPTH);
  assign fifo_wr   = tag_v_q[PP_LATENCY];

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    ch_ready  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = rr_ptr_q + CW'(i);
      if (!gnt_found && ch_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    if (en && credit_ok && !rst && gnt_found) ch_ready[gnt_idx] = 1'b1;
    xfer = |(ch_valid & ch_ready);
  end

  always_comb begin
    rr_ptr_d    = xfer ? gnt_idx + CW'(1) : rr_ptr_q;
    pp_in_d     = xfer ? ch_data[gnt_idx*SAMPLE_W +: SAMPLE_W] : '0;
    tag_v_d     = '0;
    tag_ch_d    = '0;
    tag_v_d[0]  = xfer;
    tag_ch_d[0] = gnt_idx;
    for (int s = 1; s <= PP_LATENCY; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_ch_d[s] = tag_ch_q[s-1];
    end
    inflight_d  = inflight_q + NW'(xfer) - NW'(fifo_wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      pp_in_q    <= '0;
      tag_v_q    <= '0;
      tag_ch_q   <= '0;
      inflight_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pp_in_q    <= pp_in_d;
      tag_v_q    <= tag_v_d;
      tag_ch_q   <= tag_ch_d;
      inflight_q <= inflight_d;
    end
  end

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({tag_ch_q[PP_LATENCY], pp_out}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd_data),
    .valid   (out_valid),
    .count   (fifo_count)
  );

  assign pp_in    = pp_in_q;
  assign out_data = fifo_rd_data[SAMPLE_W-1:0];
  assign out_ch   = fifo_rd_data[EW-1:SAMPLE_W];
  assign busy     = (inflight_q != '0) || out_valid;
endmodule

// File: tb/tb_audio_channel_scheduler.sv
// Scoreboard bench for audio_channel_scheduler with an identity, one-cycle preprocessor model.
module tb_audio_channel_scheduler;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, out_ready = 1'b0;
  logic [3:0]  ch_valid = '0;
  logic [3:0]  ch_ready;
  logic [63:0] ch_data = '0;
  logic [15:0] pp_in, out_data;
  logic [15:0] pp_out = '0;
  logic        out_valid, busy;
  logic [1:0]  out_ch;

  int total = 0, bad = 0, n_out = 0, n_xfer = 0, cyc = 0;

  // reference model state, advanced once per cycle at the falling edge
  int          m_rr = 0, m_cnt = 0, gk = 0;
  logic [1:0]  m_pipe = '0;
  logic [3:0]  er;
  logic        m_wr, m_pop;
  logic [17:0] sb[$];
  logic [17:0] exp_item;

  audio_channel_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_data   (ch_data),
    .pp_in     (pp_in),
    .pp_out    (pp_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    pp_out <= pp_in;
  end

  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (ch_ready !== 4'b0000) begin
        bad++;
        $display("FAIL ready_in_reset: got %b want 0000", ch_ready);
      end
      m_rr = 0; m_cnt = 0; m_pipe = '0;
      sb.delete();
    end else begin
      er = '0;
      gk = 0;
      if (en && (int'(m_pipe[0]) + int'(m_pipe[1]) + m_cnt < 4)) begin
        for (int i = 0; i < 4; i++) begin
          if (er == 4'b0000 && ch_valid[(m_rr + i) % 4]) begin
            gk = (m_rr + i) % 4;
            er[gk] = 1'b1;
          end
        end
      end
      total++;
      if (ch_ready !== er) begin
        bad++;
        $display("FAIL grant cyc=%0d: got %b want %b", cyc, ch_ready, er);
      end
      total++;
      if (out_valid !== (m_cnt != 0)) begin
        bad++;
        $display("FAIL out_valid cyc=%0d: got %b want %b", cyc, out_valid, (m_cnt != 0));
      end
      total++;
      if (busy !== ((m_pipe != 2'b00) || (m_cnt != 0))) begin
        bad++;
        $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, ((m_pipe != 2'b00) || (m_cnt != 0)));
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_out++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output cyc=%0d: got ch=%0d data=%h want none", cyc, out_ch, out_data);
        end else begin
          exp_item = sb.pop_front();
          if ({out_ch, out_data} !== exp_item) begin
            bad++;
            $display("FAIL output cyc=%0d: got ch=%0d data=%h want ch=%0d data=%h",
                     cyc, out_ch, out_data, exp_item[17:16], exp_item[15:0]);
          end
        end
      end
      m_pop = (m_cnt != 0) && out_ready;
      m_wr  = m_pipe[1];
      m_pipe = {m_pipe[0], (er != 4'b0000)};
      if (er != 4'b0000) begin
        sb.push_back({gk[1:0], ch_data[gk*16 +: 16]});
        m_rr = (gk + 1) % 4;
        n_xfer++;
      end
      m_cnt = m_cnt + int'(m_wr) - int'(m_pop);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b0; ch_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
    step();
  endtask

  task automatic test_reset;
    en = 1'b1; ch_valid = 4'hF; ch_data = {4{16'h1234}}; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ch_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want 0000", ch_ready); end
    total++; if (pp_in !== 16'h0) begin bad++; $display("FAIL rst_pp_in: got %h want 0000", pp_in); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    int t0, n;
    do_reset();
    ch_data = '0; ch_data[15:0] = 16'd1000; ch_valid = 4'b0001; out_ready = 1'b1; en = 1'b1;
    @(negedge clk);
    t0 = cyc;
    total++; if (ch_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", ch_ready); end
    step();
    ch_valid = '0;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (out_valid !== 1'b1 || cyc - t0 != 3) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles (valid=%b) want 3", cyc - t0, out_valid);
    end
    total++;
    if (out_data !== 16'd1000 || out_ch !== 2'd0) begin
      bad++;
      $display("FAIL single_data: got ch=%0d data=%0d want ch=0 data=1000", out_ch, out_data);
    end
    step();
  endtask

  task automatic test_round_robin;
    bit ok;
    do_reset();
    en = 1'b1; out_ready = 1'b1; ch_valid = 4'hF;
    for (int i = 0; i < 12; i++) begin
      ch_data = {$urandom, $urandom};
      @(negedge clk);
      total++;
      if (ch_ready !== 4'(1 << (i % 4))) begin
        bad++;
        $display("FAIL rr_grant i=%0d: got %b want %b", i, ch_ready, 4'(1 << (i % 4)));
      end
      step();
    end
    ch_valid = '0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure;
    int nx, base, n;
    bit ok;
    do_reset();
    en = 1'b1; out_ready = 1'b0; ch_valid = 4'hF;
    ch_data = {16'hFC18, 16'h7FFF, 16'h8000, 16'h0123};
    nx = 0;
    repeat (10) begin
      @(negedge clk);
      if (ch_ready !== 4'b0000) nx++;
      step();
    end
    total++; if (nx != 4) begin bad++; $display("FAIL bp_transfers: got %0d want 4", nx); end
    @(negedge clk);
    total++; if (ch_ready !== 4'b0000) begin bad++; $display("FAIL bp_stalled: got %b want 0000", ch_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_held: got %b want 1", out_valid); end
    step();
    base = n_xfer;
    out_ready = 1'b1;
    n = 0;
    while (n_xfer - base < 2 && n < 20) begin
      step();
      n++;
    end
    total++; if (n_xfer - base < 2) begin bad++; $display("FAIL bp_resume: got %0d grants want >=2", n_xfer - base); end
    ch_valid = '0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_en_drop;
    int base_out, base_x;
    bit ok;
    do_reset();
    base_out = n_out; base_x = n_xfer;
    en = 1'b1; out_ready = 1'b1; ch_valid = 4'hF;
    ch_data = {16'd44, 16'd33, 16'hFFEA, 16'd11};
    repeat (2) begin
      @(negedge clk);
      step();
    end
    ch_valid = '0;
    step();
    en = 1'b0; ch_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (ch_ready !== 4'b0000) begin bad++; $display("FAIL en_off_ready i=%0d: got %b want 0000", i, ch_ready); end
      step();
    end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL en_busy_fall: got busy=%b want 0", busy); end
    total++; if (n_out - base_out != 2) begin bad++; $display("FAIL en_outputs: got %0d want 2", n_out - base_out); end
    total++; if (n_xfer - base_x != 2) begin bad++; $display("FAIL en_transfers: got %0d want 2", n_xfer - base_x); end
    ch_valid = '0;
  endtask

  task automatic test_reset_mid;
    int base_out;
    do_reset();
    en = 1'b1; out_ready = 1'b0; ch_valid = 4'hF;
    ch_data = {16'd4, 16'd3, 16'd2, 16'd1};
    repeat (3) begin
      @(negedge clk);
      step();
    end
    rst = 1'b1; ch_valid = '0;
    @(negedge clk);
    step();
    rst = 1'b0; out_ready = 1'b1;
    base_out = n_out;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    step();
    repeat (6) step();
    total++; if (n_out != base_out) begin bad++; $display("FAIL rmid_stale: got %0d outputs want 0", n_out - base_out); end
    ch_valid = 4'hF;
    @(negedge clk);
    total++; if (ch_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first_grant: got %b want 0001", ch_ready); end
    step();
    ch_valid = '0;
    repeat (6) step();
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset();
    en = 1'b1; out_ready = 1'b1; ch_valid = 4'b0100;
    ch_data = {16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0};
    @(negedge clk);
    total++; if (ch_ready !== 4'b0100) begin bad++; $display("FAIL wrap_first: got %b want 0100", ch_ready); end
    step();
    @(negedge clk);
    total++; if (ch_ready !== 4'b0100) begin bad++; $display("FAIL wrap_grant: got %b want 0100", ch_ready); end
    step();
    ch_valid = 4'hF;
    @(negedge clk);
    total++; if (ch_ready !== 4'b1000) begin bad++; $display("FAIL wrap_rr_ptr: got %b want 1000", ch_ready); end
    step();
    ch_valid = '0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_drain: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    repeat (4) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/audio_channel_scheduler.md
AUDIO_CHANNEL_SCHEDULER -- requirements
Module: audio_channel_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting audio channels (power of two, 2..8).
REQ-002 Parameter PP_LATENCY, default 1, clock cycles from pp_in change to matching pp_out.
REQ-003 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >= 2).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  scheduling enable; 0 blocks new grants.
REQ-007 ch_valid  input  NUM_CH  per-channel sample valid.
REQ-008 ch_ready  output  NUM_CH  per-channel accept, one-hot or zero.
REQ-009 ch_data  input  16*NUM_CH  packed signed samples; channel k at bits [16k+15:16k].
REQ-010 pp_in  output  16  signed sample to shared audio_preprocessor audio_in.
REQ-011 pp_out  input  16  signed result from audio_preprocessor audio_out.
REQ-012 out_valid  output  1  result FIFO non-empty.
REQ-013 out_ready  input  1  consumer accept; pop when out_valid and out_ready.
REQ-014 out_data  output  16  signed processed sample at FIFO head.
REQ-015 out_ch  output  log2(NUM_CH)  source channel of out_data.
REQ-016 busy  output  1  high when any sample in flight or FIFO non-empty.

Function
REQ-017 Grant: when en=1 and credit available, ch_ready asserts combinationally for the first channel with ch_valid=1 searching from rr_ptr upward, wrapping.
REQ-018 Transfer occurs on a cycle where ch_valid[k] and ch_ready[k] are both 1; at most one transfer per cycle.
REQ-019 On transfer from channel k, rr_ptr <= (k+1) mod NUM_CH; otherwise rr_ptr holds.
REQ-020 pp_in registers the transferred sample at the transfer edge; on cycles without transfer, pp_in registers 0.
REQ-021 A tag (valid bit + channel id) delay line of 1+PP_LATENCY stages aligns each transfer with its pp_out; tagged pp_out is written to the FIFO with its channel id.
REQ-022 Latency: transfer at cycle T -> out_valid with that sample no earlier than cycle T+2+PP_LATENCY (T+3 at default).
REQ-023 Credit: inflight + fifo_count < FIFO_DEPTH using registered counts; a pop in the same cycle does not free credit until the next cycle.
REQ-024 FIFO never overflows; a write while full is a design error flagged by an assertion.
REQ-025 Simultaneous FIFO write and pop: count unchanged, both take effect.
REQ-026 Output order equals transfer order; no sample dropped or duplicated.
REQ-027 en falling mid-operation: no new grants; in-flight samples complete and enter FIFO.
REQ-028 pp_out on untagged cycles is ignored.
REQ-029 Sample values pass through unmodified in width; no saturation or truncation in this block.

Reset
REQ-030 While rst=1: ch_ready=0, pp_in=0, out_valid=0, out_data=0, out_ch=0, busy=0, rr_ptr=0, inflight=0, FIFO empty, tag line cleared.
REQ-031 Reset asserted mid-operation discards all in-flight and buffered samples; first grant after release follows REQ-017 with rr_ptr=0.

Structure
REQ-032 Shared package audio_pkg holds SAMPLE_W=16, default NUM_CH, channel-id width constant and sample typedef.
REQ-033 Result storage is one sub-module audio_sample_fifo (synchronous, FWFT, parameterised depth/width, count output).

Verification
REQ-034 Single channel: ch_valid=0001, ch_data[15:0]=1000, out_ready=1, preprocessor model = identity delay 1 -> out_valid at T+3, out_data=1000, out_ch=0.
REQ-035 All four valid continuously, out_ready=1 -> grants cycle 0,1,2,3,0,... one per cycle; out_ch sequence 0,1,2,3 repeats.
REQ-036 out_ready=0, all valid -> exactly 4 transfers then ch_ready=0; out_ready=1 -> 4 outputs in order, grants resume.
REQ-037 en dropped one cycle after 2 transfers -> both results emerge, no further ch_ready, busy falls after last pop.
REQ-038 rst pulsed with 2 samples in flight and 1 in FIFO -> next cycle out_valid=0, busy=0, no stale output afterwards.
REQ-039 Channel 2 only valid with rr_ptr=3 -> grant to channel 2 via wrap, rr_ptr becomes 3.
